mem_stage_skid: RTL
===================

// Module: mem_stage_skid
// PURPOSE
//  Parametrised pipeline-stage register: the next generation of the EX->MEM stage latch.
//  Moves a control bundle plus NCH data channels from one stage to the next.
//  Adds a valid/ready handshake, a one-entry skid buffer, flush, and bubble zeroing.
//  Adds saturating stall/flush event counters for the performance counters.
//  Sits between any two CPU pipeline stages (EX/MEM first, ID/EX and MEM/WB next).
// PARAMETERS
//  CTRL_W  4   width of control bundle (RegWrite,MemtoReg,MemWrite,hilowrite for EX/MEM)
//  DATA_W  32  width of each data channel
//  NCH     4   number of data channels (aluout,writedata,writereg,pcbranch)
//  CNT_W   16  width of each event counter
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  flush      in   1             synchronous kill of all held entries
//  in_valid   in   1             upstream presents an entry
//  in_ready   out  1             stage can accept; registered, = !skid_valid
//  in_ctrl    in   CTRL_W        upstream control bundle
//  in_data    in   NCH*DATA_W    upstream channels, channel k at [k*DATA_W +: DATA_W]
//  out_valid  out  1             main entry valid
//  out_ready  in   1             downstream accepts this cycle
//  out_ctrl   out  CTRL_W        main control; forced 0 when !out_valid (bubble)
//  out_data   out  NCH*DATA_W    main data; holds last value when !out_valid
//  stall_cnt  out  CNT_W         cycles with out_valid && !out_ready, saturating
//  flush_cnt  out  CNT_W         flush cycles that discarded >=1 valid entry, saturating
// BEHAVIOUR
//  Storage: main reg (drives outputs) and skid reg; states EMPTY / FULL / SKID.
//  acc = in_valid && in_ready; drn = out_valid && out_ready.
//  EMPTY: acc -> load main, FULL. Latency in->out exactly 1 cycle.
//  FULL:  acc&&drn -> load main, stay FULL. acc&&!drn -> load skid, SKID.
//         !acc&&drn -> EMPTY. Otherwise hold.
//  SKID:  in_ready=0, so acc is impossible. drn -> main<=skid, FULL. Otherwise hold.
//  Ordering is strictly FIFO. No entry is dropped or duplicated absent flush/reset.
//  Outputs depend only on registers; no combinational in->out path.
//  flush=1: next state EMPTY, and any same-cycle acc is discarded.
//    flush_cnt increments if out_valid was 1 that cycle.
//    in_ready=1 on the cycle after flush.
//  reset=1: dominates flush. State EMPTY; out_valid=0; in_ready=1; out_ctrl=0;
//    out_data=0; skid data=0; stall_cnt=0; flush_cnt=0.
//  Reset mid-SKID: both entries are lost; no counter increments that cycle.
//  Counters stop at 2^CNT_W-1 and never wrap.
//  stall_cnt does not count a cycle in which flush=1.
//  Data regs load only on acc or skid->main transfer (no gratuitous toggling).
// TESTING
//  1 Pass-through: out_ready=1; in_valid=1 for 3 cycles with in_ctrl 4'hF and
//    ch0 = 1,2,3 -> out_valid 1 cycle later; ch0 = 1,2,3 on consecutive cycles;
//    in_ready stays 1; stall_cnt=0.
//  2 Backpressure: out_ready=0; push A=0x11, then B=0x22 -> in_ready=0 after B.
//    Raise out_ready -> A then B out in order; stall_cnt=2 (or per stalled cycles).
//  3 Flush in SKID: state SKID, flush=1 with in_valid=1 -> next cycle out_valid=0,
//    out_ctrl=0, in_ready=1; flush_cnt=1; the pushed entry never appears.
//  4 Flush when EMPTY: flush=1 with no valid entries -> flush_cnt stays 0.
//  5 Reset priority: reset=1 and flush=1 in SKID -> all outputs at reset values;
//    flush_cnt=0.
//  6 Saturation: CNT_W=3, out_ready=0 with valid entry for 10 cycles ->
//    stall_cnt=7 and holds at 7.

Source files
------------

// File: rtl/mem_stage_skid.sv
`default_nettype none
// ============================================================================
// Module : mem_stage_skid
// Brief  : Pipeline stage latch with valid/ready handshake, one-entry skid
//          buffer, flush, bubble zeroing and saturating stall/flush counters.
// Rev    : 1.0  initial release
// ============================================================================
module mem_stage_skid #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32,
    parameter int NCH    = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [NCH*DATA_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [CTRL_W-1:0]       r_mainCtrl;
    logic [NCH*DATA_W-1:0]   r_mainData;
    logic [CTRL_W-1:0]       r_skidCtrl;
    logic [NCH*DATA_W-1:0]   r_skidData;
    logic [CNT_W-1:0]        r_stallCnt;
    logic [CNT_W-1:0]        r_flushCnt;
    logic                    w_acc;
    logic                    w_drn;
    logic                    w_loadMain;
    logic                    w_loadSkid;
    logic                    w_mainFromSkid;

    // Handshake flags are pure decodes of the state register.
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = (r_state != SKID);
    assign w_acc     = in_valid && in_ready;
    assign w_drn     = out_valid && out_ready;

    always_comb begin
        w_nextState    = r_state;
        w_loadMain     = 1'b0;
        w_loadSkid     = 1'b0;
        w_mainFromSkid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_nextState = FULL;
                    w_loadMain  = 1'b1;
                end
            end
            FULL: begin
                if (w_acc && w_drn) begin
                    w_loadMain = 1'b1;
                end else if (w_acc) begin
                    w_nextState = SKID;
                    w_loadSkid  = 1'b1;
                end else if (w_drn) begin
                    w_nextState = EMPTY;
                end
            end
            SKID: begin
                if (w_drn) begin
                    w_nextState    = FULL;
                    w_mainFromSkid = 1'b1;
                end
            end
            default: w_nextState = EMPTY;
        endcase
        // Flush kills held entries and any same-cycle accept; data regs keep their value.
        if (flush) begin
            w_nextState    = EMPTY;
            w_loadMain     = 1'b0;
            w_loadSkid     = 1'b0;
            w_mainFromSkid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mainCtrl <= '0;
            r_mainData <= '0;
            r_skidCtrl <= '0;
            r_skidData <= '0;
        end else begin
            if (w_loadMain) begin
                r_mainCtrl <= in_ctrl;
                r_mainData <= in_data;
            end else if (w_mainFromSkid) begin
                r_mainCtrl <= r_skidCtrl;
                r_mainData <= r_skidData;
            end
            if (w_loadSkid) begin
                r_skidCtrl <= in_ctrl;
                r_skidData <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && (r_stallCnt != c_CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (flush && out_valid && (r_flushCnt != c_CNT_MAX)) begin
                r_flushCnt <= r_flushCnt + 1'b1;
            end
        end
    end

    assign out_ctrl  = out_valid ? r_mainCtrl : '0;
    assign out_data  = r_mainData;
    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;

endmodule
`default_nettype wire
